mem_byte_arbiter: RTL and testbench

- Shares one single-port, byte-wide, asynchronous-read memory between two requesters: the instruction-fetch port (I) and the data load/store port (D).
- Each granted request becomes a 4-beat byte sequence at addresses base..base+3.
- Bytes are assembled big-endian: the byte at the base address lands in bits [31:24].
- Sits between the fetch/LSU logic and the unified byte memory array.

---
 rtl/mem_byte_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_byte_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_arbiter.sv
// Arbitrates a single-port byte-wide memory between the fetch (I) and load/store (D)
// ports; each grant becomes four byte beats assembled big-endian into a word.
//   state   | meaning
//   IDLE    | waiting for a request, round-robin grant on tie
//   XFER    | four byte beats at latched address + beat
//   DONE    | one-cycle done pulse, owner rdata valid
module mem_byte_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [DATA_WIDTH-1:0] i_rdata,
   output logic                  i_done,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   input  logic [3:0]            d_wmask,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_done,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [7:0]            mem_wdata,
   input  logic [7:0]            mem_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int SHW = DATA_WIDTH - 8;

   state_t                state_q, state_d;
   logic [1:0]            beat_q, beat_d;
   logic                  last_d_q, last_d_d;
   logic                  own_d_q, own_d_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [3:0]            wmask_q, wmask_d;
   logic [SHW-1:0]        shadow_q, shadow_d;
   logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
   logic                  i_done_q, i_done_d;
   logic                  d_done_q, d_done_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  mem_we_q, mem_we_d;
   logic [7:0]            mem_wdata_q, mem_wdata_d;
   logic                  busy_q, busy_d;
   logic                  grant_dport;
   logic [1:0]            beat_nx;

   function automatic logic [7:0] word_byte(input logic [DATA_WIDTH-1:0] w, input logic [1:0] k);
      case (k)
         2'd0:    word_byte = w[DATA_WIDTH-1  -: 8];
         2'd1:    word_byte = w[DATA_WIDTH-9  -: 8];
         2'd2:    word_byte = w[DATA_WIDTH-17 -: 8];
         default: word_byte = w[DATA_WIDTH-25 -: 8];
      endcase
   endfunction

   // memory-side outputs are registered one beat ahead so they are glitch-free
   // for the whole beat; mem_rdata is then captured at the edge ending the beat
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      last_d_d    = last_d_q;
      own_d_d     = own_d_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      shadow_d    = shadow_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_done_d    = 1'b0;
      d_done_d    = 1'b0;
      mem_addr_d  = '0;
      mem_we_d    = 1'b0;
      mem_wdata_d = '0;
      busy_d      = 1'b0;
      grant_dport = 1'b0;
      beat_nx     = beat_q + 2'd1;

      case (state_q)
         ST_IDLE: begin
            if (i_req || d_req) begin
               grant_dport = d_req && (!i_req || !last_d_q);
               own_d_d     = grant_dport;
               last_d_d    = grant_dport;
               addr_d      = grant_dport ? d_addr : i_addr;
               we_d        = grant_dport && d_we;
               wdata_d     = d_wdata;
               wmask_d     = d_wmask;
               beat_d      = 2'd0;
               state_d     = ST_XFER;
               busy_d      = 1'b1;
               mem_addr_d  = addr_d;
               mem_we_d    = we_d && d_wmask[3];
               mem_wdata_d = we_d ? word_byte(d_wdata, 2'd0) : 8'h00;
            end
         end
         ST_XFER: begin
            busy_d = 1'b1;
            if (!we_q) shadow_d = {shadow_q[SHW-9:0], mem_rdata};
            if (beat_q == 2'd3) begin
               state_d = ST_DONE;
               if (own_d_q) begin
                  d_done_d = 1'b1;
                  if (!we_q) d_rdata_d = {shadow_q, mem_rdata};
               end else begin
                  i_done_d  = 1'b1;
                  i_rdata_d = {shadow_q, mem_rdata};
               end
            end else begin
               beat_d      = beat_nx;
               mem_addr_d  = addr_q + ADDR_WIDTH'(beat_nx);
               mem_we_d    = we_q && wmask_q[2'd3 - beat_nx];
               mem_wdata_d = we_q ? word_byte(wdata_q, beat_nx) : 8'h00;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         beat_q      <= 2'd0;
         last_d_q    <= 1'b0;
         own_d_q     <= 1'b0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         wmask_q     <= 4'd0;
         shadow_q    <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_done_q    <= 1'b0;
         d_done_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= 8'h00;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         last_d_q    <= last_d_d;
         own_d_q     <= own_d_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         shadow_q    <= shadow_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         i_done_q    <= i_done_d;
         d_done_q    <= d_done_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
      end
   end

   assign i_rdata   = i_rdata_q;
   assign i_done    = i_done_q;
   assign d_rdata   = d_rdata_q;
   assign d_done    = d_done_q;
   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_byte_arbiter.sv
// Bench for mem_byte_arbiter: byte memory plus a transaction-level reference
// (round-robin winner, big-endian word from a reference memory image).
module tb_mem_byte_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req, d_req, d_we;
   logic [11:0] i_addr, d_addr;
   logic [31:0] i_rdata, d_rdata, d_wdata;
   logic [3:0]  d_wmask;
   logic        i_done, d_done;
   logic [11:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        busy;

   logic [7:0]  mem     [0:4095];
   logic [7:0]  ref_mem [0:4095];
   logic        tb_we = 1'b0;
   logic [11:0] tb_waddr = '0;
   logic [7:0]  tb_wdata = '0;

   int          n_vec = 0;
   int          n_err = 0;
   bit          m_last_d;
   logic [31:0] exp_i_rdata, exp_d_rdata;

   mem_byte_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wmask(d_wmask), .d_rdata(d_rdata), .d_done(d_done),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else if (tb_we) mem[tb_waddr] <= tb_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic poke(input logic [11:0] a, input logic [7:0] v);
      ref_mem[a] = v;
      tb_we = 1'b1; tb_waddr = a; tb_wdata = v;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   function automatic logic [31:0] word_at(input logic [11:0] a);
      return {ref_mem[a], ref_mem[a + 12'd1], ref_mem[a + 12'd2], ref_mem[a + 12'd3]};
   endfunction

   // called at the negedge of the IDLE cycle in which the owner's req is sampled
   task automatic serve(input bit is_d, input bit we, input logic [11:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask, input bit drop);
      logic [31:0] word;
      logic [11:0] a;
      logic [7:0]  b;
      bit          wr;
      word = word_at(addr);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         a  = addr + 12'(k);
         b  = wdata[31 - 8*k -: 8];
         wr = we && wmask[3 - k];
         chk("mem_addr", 32'(mem_addr), 32'(a));
         chk("mem_we", 32'(mem_we), 32'(wr));
         if (wr) begin
            chk("mem_wdata", 32'(mem_wdata), 32'(b));
            ref_mem[a] = b;
         end
         chk("busy_xfer", 32'(busy), 32'd1);
         chk("i_done_xfer", 32'(i_done), 32'd0);
         chk("d_done_xfer", 32'(d_done), 32'd0);
         if (k == 1) begin
            if (is_d) begin
               d_addr = 12'($urandom); d_we = 1'($urandom);
               d_wdata = $urandom; d_wmask = 4'($urandom);
            end else begin
               i_addr = 12'($urandom);
            end
         end
      end
      @(negedge clk);
      chk("i_done", 32'(i_done), 32'(!is_d));
      chk("d_done", 32'(d_done), 32'(is_d));
      chk("busy_done", 32'(busy), 32'd1);
      if (!we) begin
         if (is_d) exp_d_rdata = word;
         else      exp_i_rdata = word;
      end
      chk("i_rdata", i_rdata, exp_i_rdata);
      chk("d_rdata", d_rdata, exp_d_rdata);
      if (drop) begin
         if (is_d) d_req = 1'b0;
         else      i_req = 1'b0;
      end
   endtask

   task automatic idle_chk();
      @(negedge clk);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("mem_addr_idle", 32'(mem_addr), 32'd0);
      chk("mem_we_idle", 32'(mem_we), 32'd0);
      chk("i_done_idle", 32'(i_done), 32'd0);
      chk("d_done_idle", 32'(d_done), 32'd0);
   endtask

   task automatic txn(input bit ri, input bit rd, input logic [11:0] ia, input bit dwe,
                      input logic [11:0] da, input logic [31:0] dwd, input logic [3:0] dm);
      bit first_d;
      i_req = ri; d_req = rd; i_addr = ia;
      d_we = dwe; d_addr = da; d_wdata = dwd; d_wmask = dm;
      if (!ri && !rd) begin
         idle_chk();
         return;
      end
      first_d  = rd && (!ri || !m_last_d);
      m_last_d = first_d;
      if (first_d) serve(1'b1, dwe, da, dwd, dm, 1'b1);
      else         serve(1'b0, 1'b0, ia, 32'd0, 4'd0, 1'b1);
      idle_chk();
      if (ri && rd) begin
         m_last_d = !first_d;
         if (!first_d) serve(1'b1, dwe, da, dwd, dm, 1'b1);
         else          serve(1'b0, 1'b0, ia, 32'd0, 4'd0, 1'b1);
         idle_chk();
      end
   endtask

   initial begin
      logic [7:0] old101, old103;
      i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0;
      d_wdata = '0; d_wmask = '0;
      m_last_d = 1'b0; exp_i_rdata = '0; exp_d_rdata = '0;
      @(negedge clk);
      for (int i = 0; i < 4096; i++) poke(12'(i), 8'($urandom));

      chk("rst_i_rdata", i_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_i_done", 32'(i_done), 32'd0);
      chk("rst_d_done", 32'(d_done), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      poke(12'h010, 8'h13); poke(12'h011, 8'h05);
      poke(12'h012, 8'h00); poke(12'h013, 8'h00);
      txn(1, 0, 12'h010, 0, 12'h0, 32'h0, 4'h0);
      chk("fetch_word", i_rdata, 32'h13050000);

      txn(1, 1, 12'($urandom), 0, 12'($urandom), 32'h0, 4'h0);
      txn(1, 1, 12'($urandom), 0, 12'($urandom), 32'h0, 4'h0);

      old101 = ref_mem[12'h101];
      old103 = ref_mem[12'h103];
      txn(0, 1, 12'h0, 1, 12'h100, 32'hAABBCCDD, 4'b1010);
      chk("mem_100", 32'(mem[12'h100]), 32'h0000_00AA);
      chk("mem_101", 32'(mem[12'h101]), 32'(old101));
      chk("mem_102", 32'(mem[12'h102]), 32'h0000_00CC);
      chk("mem_103", 32'(mem[12'h103]), 32'(old103));

      txn(0, 1, 12'h0, 0, 12'hFFE, 32'h0, 4'h0);
      chk("wrap_word", d_rdata, {mem[12'hFFE], mem[12'hFFF], mem[12'h000], mem[12'h001]});

      // abort an I read during beat 2
      i_req = 1'b1; i_addr = 12'h040;
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_mem_addr", 32'(mem_addr), 32'd0);
      chk("abort_mem_we", 32'(mem_we), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_i_rdata", i_rdata, 32'd0);
      chk("abort_d_rdata", d_rdata, 32'd0);
      chk("abort_i_done", 32'(i_done), 32'd0);
      i_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_last_d = 1'b0; exp_i_rdata = '0; exp_d_rdata = '0;
      repeat (6) idle_chk();
      txn(1, 0, 12'h040, 0, 12'h0, 32'h0, 4'h0);

      // held i_req: a second fetch follows in the next IDLE
      i_req = 1'b1; d_req = 1'b0; i_addr = 12'h200;
      m_last_d = 1'b0;
      serve(1'b0, 1'b0, 12'h200, 32'd0, 4'd0, 1'b0);
      i_addr = 12'h300;
      idle_chk();
      serve(1'b0, 1'b0, 12'h300, 32'd0, 4'd0, 1'b1);
      idle_chk();

      repeat (150) begin
         txn(1'($urandom), 1'($urandom), 12'($urandom), 1'($urandom),
             12'($urandom), $urandom, 4'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
